data_mem_bank: RTL

Parametrised byte-addressable data memory for the MEM stage, little-endian, with word/half/byte access. Read is registered (1-cycle latency) with sign/zero extension for lb/lh/lbu/lhu. Misaligned or illegal-mode accesses are flagged instead of being silently dropped. An optional dump port lets the debug unit stream the whole memory out word by word with a valid/ready handshake.

---
 rtl/data_mem_bank.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/data_mem_bank.sv
// -----------------------------------------------------------------------------
// data_mem_bank
//   Byte-addressable little-endian data memory for the MEM stage.
//   Word/half/byte writes and registered reads (1-cycle latency) with sign or
//   zero extension. Misaligned or illegal-mode accesses raise o_r_err/o_w_err
//   and never modify memory. An optional dump port streams every word out with
//   a valid/ready handshake.
//
//   Optional feature macro: DMEM_DUMP_EN
//     defined   : dump FSM and dump ports are built
//     undefined : dump outputs are tied to 0, dump inputs are ignored
//
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset (clears memory)
//   i_r_addr/en/addressing  read byte address, request, mode (00 W, 01 H, 11 B)
//   i_r_unsigned            1 = zero-extend, 0 = sign-extend (half/byte)
//   i_w_data/addr/en/...    write data (LSB aligned), address, request, mode
//   i_dump_start/ready      dump start pulse, consumer ready
//   o_r_data/valid/err      registered read result
//   o_w_err                 registered pulse: previous write was rejected
//   o_dump_*                dump word, its byte address, valid, busy, done
// -----------------------------------------------------------------------------
module data_mem_bank #(
  parameter int NB_DATA_BUS = 32,
  parameter int NB_DATA     = 8,
  parameter int N_ADDRESS   = 256,
  parameter int NB_ADDRESS  = $clog2(N_ADDRESS)
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [NB_ADDRESS-1:0]  i_r_addr,
  input  logic                   i_r_en,
  input  logic [1:0]             i_r_addressing,
  input  logic                   i_r_unsigned,
  input  logic [NB_DATA_BUS-1:0] i_w_data,
  input  logic [NB_ADDRESS-1:0]  i_w_addr,
  input  logic                   i_w_en,
  input  logic [1:0]             i_w_addressing,
  input  logic                   i_dump_start,
  input  logic                   i_dump_ready,
  output logic [NB_DATA_BUS-1:0] o_r_data,
  output logic                   o_r_valid,
  output logic                   o_r_err,
  output logic                   o_w_err,
  output logic [NB_DATA_BUS-1:0] o_dump_data,
  output logic [NB_ADDRESS-1:0]  o_dump_addr,
  output logic                   o_dump_valid,
  output logic                   o_dump_busy,
  output logic                   o_dump_done
);

  localparam logic [1:0] MODE_WORD = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_BYTE = 2'b11;

  function automatic logic is_legal(input logic [1:0] mode,
                                    input logic [NB_ADDRESS-1:0] addr);
    case (mode)
      MODE_WORD: return (addr[1:0] == 2'b00);
      MODE_HALF: return (addr[0] == 1'b0);
      MODE_BYTE: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

  // Register array (not block RAM): the whole memory must clear on reset.
  logic [NB_DATA-1:0] mem_reg [N_ADDRESS];

  // ---------------------------------------------------------------------------
  // Write path: each byte decodes whether it is hit and which data lane feeds it
  // ---------------------------------------------------------------------------
  logic                w_legal;
  logic [N_ADDRESS-1:0] byte_we;
  logic [NB_DATA-1:0]  byte_wdata [N_ADDRESS];

  assign w_legal = is_legal(i_w_addressing, i_w_addr);

  for (genvar gi = 0; gi < N_ADDRESS; gi++) begin : g_byte
    localparam logic [NB_ADDRESS-1:0] BYTE_ADDR = NB_ADDRESS'(gi);
    logic       hit;
    logic [1:0] lane;

    always_comb begin
      hit  = 1'b0;
      lane = 2'd0;
      case (i_w_addressing)
        MODE_WORD: begin
          hit  = (BYTE_ADDR[NB_ADDRESS-1:2] == i_w_addr[NB_ADDRESS-1:2]);
          lane = BYTE_ADDR[1:0];
        end
        MODE_HALF: begin
          hit  = (BYTE_ADDR[NB_ADDRESS-1:1] == i_w_addr[NB_ADDRESS-1:1]);
          lane = {1'b0, BYTE_ADDR[0]};
        end
        MODE_BYTE: begin
          hit  = (BYTE_ADDR == i_w_addr);
          lane = 2'd0;
        end
        default: begin
          hit  = 1'b0;
          lane = 2'd0;
        end
      endcase
    end

    assign byte_we[gi]    = i_w_en & w_legal & hit;
    assign byte_wdata[gi] = i_w_data[lane*NB_DATA +: NB_DATA];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < N_ADDRESS; i++) mem_reg[i] <= '0;
    end else begin
      for (int i = 0; i < N_ADDRESS; i++)
        if (byte_we[i]) mem_reg[i] <= byte_wdata[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: fetch the enclosing aligned word, then pick and extend a lane.
  // Reading mem_reg before the non-blocking update gives read-before-write.
  // ---------------------------------------------------------------------------
  logic [NB_DATA_BUS-1:0] r_word;
  logic [15:0]            r_half;
  logic [NB_DATA-1:0]     r_byte;
  logic [NB_DATA_BUS-1:0] r_ext;
  logic                   r_legal;

  for (genvar gi = 0; gi < 4; gi++) begin : g_rlane
    assign r_word[gi*NB_DATA +: NB_DATA] = mem_reg[{i_r_addr[NB_ADDRESS-1:2], 2'(gi)}];
  end

  assign r_half  = i_r_addr[1] ? r_word[31:16] : r_word[15:0];
  assign r_byte  = r_word[i_r_addr[1:0]*NB_DATA +: NB_DATA];
  assign r_legal = is_legal(i_r_addressing, i_r_addr);

  always_comb begin
    r_ext = '0;
    case (i_r_addressing)
      MODE_WORD: r_ext = r_word;
      MODE_HALF: r_ext = {{16{~i_r_unsigned & r_half[15]}}, r_half};
      MODE_BYTE: r_ext = {{24{~i_r_unsigned & r_byte[7]}}, r_byte};
      default:   r_ext = '0;
    endcase
  end

  logic [NB_DATA_BUS-1:0] r_data_reg;
  logic                   r_valid_reg;
  logic                   r_err_reg;
  logic                   w_err_reg;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data_reg  <= '0;
      r_valid_reg <= 1'b0;
      r_err_reg   <= 1'b0;
      w_err_reg   <= 1'b0;
    end else begin
      w_err_reg <= i_w_en & ~w_legal;
      if (i_r_en) begin
        r_valid_reg <= 1'b1;
        r_err_reg   <= ~r_legal;
        r_data_reg  <= r_legal ? r_ext : '0;
      end else begin
        // o_r_data deliberately holds the last result
        r_valid_reg <= 1'b0;
        r_err_reg   <= 1'b0;
      end
    end
  end

  assign o_r_data  = r_data_reg;
  assign o_r_valid = r_valid_reg;
  assign o_r_err   = r_err_reg;
  assign o_w_err   = w_err_reg;

  // ---------------------------------------------------------------------------
  // Dump port
  // ---------------------------------------------------------------------------
`ifdef DMEM_DUMP_EN
  typedef enum logic [1:0] {
    DUMP_IDLE,
    DUMP_SCAN,
    DUMP_DONE
  } dump_state_t;

  localparam logic [NB_ADDRESS-1:0] LAST_WORD_ADDR = NB_ADDRESS'(N_ADDRESS - 4);

  dump_state_t            dump_state_reg;
  logic [NB_ADDRESS-1:0]  dump_addr_reg;
  logic                   dump_valid_reg;
  logic                   dump_busy_reg;
  logic                   dump_done_reg;
  logic [NB_DATA_BUS-1:0] dump_word;

  // Live view of memory: a write committed before acceptance shows up here.
  for (genvar gi = 0; gi < 4; gi++) begin : g_dlane
    assign dump_word[gi*NB_DATA +: NB_DATA] = mem_reg[{dump_addr_reg[NB_ADDRESS-1:2], 2'(gi)}];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      dump_state_reg <= DUMP_IDLE;
      dump_addr_reg  <= '0;
      dump_valid_reg <= 1'b0;
      dump_busy_reg  <= 1'b0;
      dump_done_reg  <= 1'b0;
    end else begin
      case (dump_state_reg)
        DUMP_IDLE: begin
          if (i_dump_start) begin
            dump_state_reg <= DUMP_SCAN;
            dump_addr_reg  <= '0;
            dump_valid_reg <= 1'b1;
            dump_busy_reg  <= 1'b1;
          end
        end
        DUMP_SCAN: begin
          if (i_dump_ready) begin
            if (dump_addr_reg == LAST_WORD_ADDR) begin
              dump_state_reg <= DUMP_DONE;
              dump_addr_reg  <= '0;
              dump_valid_reg <= 1'b0;
              dump_done_reg  <= 1'b1;
            end else begin
              dump_addr_reg <= dump_addr_reg + NB_ADDRESS'(4);
            end
          end
        end
        DUMP_DONE: begin
          dump_state_reg <= DUMP_IDLE;
          dump_done_reg  <= 1'b0;
          dump_busy_reg  <= 1'b0;
        end
        default: begin
          dump_state_reg <= DUMP_IDLE;
          dump_valid_reg <= 1'b0;
          dump_busy_reg  <= 1'b0;
          dump_done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign o_dump_data  = dump_valid_reg ? dump_word : '0;
  assign o_dump_addr  = dump_addr_reg;
  assign o_dump_valid = dump_valid_reg;
  assign o_dump_busy  = dump_busy_reg;
  assign o_dump_done  = dump_done_reg;
`else
  logic unused_dump;
  assign unused_dump = i_dump_start ^ i_dump_ready;

  assign o_dump_data  = '0;
  assign o_dump_addr  = '0;
  assign o_dump_valid = 1'b0;
  assign o_dump_busy  = 1'b0;
  assign o_dump_done  = 1'b0;
`endif

endmodule
